// File: rtl/router_pkg.sv
// Shared types and constants for the router input port front end.
package router_pkg;

  localparam int ADDR_W = 4;
  localparam int PORTS  = 16;

  typedef enum logic [2:0] {
    IN_IDLE,
    IN_ADDR,
    IN_PAD,
    IN_DATA,
    IN_DRAIN
  } inState_e;

  typedef struct packed {
    logic last;
    logic dataBit;
  } fifoEntry_t;

endpackage

// File: rtl/router_bit_fifo.sv
// Small synchronous FIFO of {last, bit} payload entries with a hook to mark the
// newest entry as the packet's final bit.
module router_bit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push_i,
  input  fifoEntry_t pushEntry_i,
  input  logic       forceLast_i,
  input  logic       pop_i,
  output fifoEntry_t popEntry_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [AW-1:0] tailIdx;
  fifoEntry_t    mem_q [DEPTH];

  // Extra pointer MSB separates the full case from the empty case.
  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign popEntry_o = mem_q[rdPtr_q[AW-1:0]];
  assign tailIdx    = wrPtr_q[AW-1:0] - AW'(1);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push_i) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (pop_i)  rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wrPtr_q[AW-1:0]] <= pushEntry_i;
    end else if (forceLast_i) begin
      mem_q[tailIdx].last <= 1'b1;
    end
  end

endmodule

// File: rtl/router_input_ctrl.sv
// Per-input-port front end: captures the serial destination address, buffers
// payload bits and replays them toward decode once the arbiter grants.
module router_input_ctrl
  import router_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              din,
  input  logic              grant,
  output logic [ADDR_W-1:0] address_o,
  output logic              request_o,
  output logic              frame_o,
  output logic              valid_o,
  output logic              dout,
  output logic              err_o
);

  localparam int              CNT_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_W - 1);

  inState_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addrShift_q, addrShift_d, addrNext;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              request_q, request_d;
  logic              err_q, err_d;
  logic              frameOut_q, validOut_q, dout_q;

  logic              takeBit, popEn, pushEn, forceLast;
  logic              fifoFull, fifoEmpty;
  fifoEntry_t        pushEntry, popEntry;

  // Replay reads registered occupancy, so a freshly pushed entry pops a cycle later.
  assign popEn     = grant && !fifoEmpty && request_q;
  assign takeBit   = !valid_n && ((state_q == IN_PAD) || (state_q == IN_DATA));
  assign pushEntry = '{last: frame_n, dataBit: din};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addrShift_d = addrShift_q;
    address_d   = address_q;
    request_d   = request_q;
    err_d       = 1'b0;
    pushEn      = 1'b0;
    forceLast   = 1'b0;
    addrNext    = addrShift_q;
    addrNext[cnt_q] = din;

    case (state_q)
      IN_IDLE: begin
        if (!frame_n) begin
          addrShift_d = {{(ADDR_W-1){1'b0}}, din};
          cnt_d       = CNT_W'(1);
          state_d     = IN_ADDR;
        end
      end
      IN_ADDR: begin
        if (frame_n) begin
          state_d   = IN_IDLE;
          request_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          addrShift_d = addrNext;
          if (cnt_q == CNT_LAST) begin
            address_d = addrNext;
            request_d = 1'b1;
            state_d   = IN_PAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      IN_PAD: begin
        if (valid_n && frame_n) begin
          state_d   = IN_IDLE;
          request_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      IN_DATA: begin
      end
      IN_DRAIN: begin
        if (!frame_n) err_d = 1'b1;
        if (popEn && popEntry.last) begin
          state_d   = IN_IDLE;
          request_d = 1'b0;
        end
      end
      default: state_d = IN_IDLE;
    endcase

    // A pop in the same cycle frees a slot before the push is judged.
    if (takeBit) begin
      state_d = frame_n ? IN_DRAIN : IN_DATA;
      if (!fifoFull || popEn) begin
        pushEn = 1'b1;
      end else begin
        err_d     = 1'b1;
        forceLast = frame_n;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IN_IDLE;
      cnt_q       <= '0;
      addrShift_q <= '0;
      address_q   <= '0;
      request_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addrShift_q <= addrShift_d;
      address_q   <= address_d;
      request_q   <= request_d;
      err_q       <= err_d;
    end
  end

  // frame_o and dout hold between pops; frame_o stays high after a packet's last bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frameOut_q <= 1'b1;
      validOut_q <= 1'b1;
      dout_q     <= 1'b0;
    end else if (popEn) begin
      frameOut_q <= popEntry.last;
      validOut_q <= 1'b0;
      dout_q     <= popEntry.dataBit;
    end else begin
      validOut_q <= 1'b1;
    end
  end

  router_bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (pushEn),
    .pushEntry_i (pushEntry),
    .forceLast_i (forceLast),
    .pop_i       (popEn),
    .popEntry_o  (popEntry),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  assign address_o = address_q;
  assign request_o = request_q;
  assign frame_o   = frameOut_q;
  assign valid_o   = validOut_q;
  assign dout      = dout_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_router_input_ctrl.sv
// Self-checking bench for router_input_ctrl: a directed vector table, hand-written
// corner sequences and randomized packets checked against a queue-based model.
module tb_router_input_ctrl;

  localparam int DEPTH      = 8;
  localparam int GR_ALWAYS  = 0;
  localparam int GR_DELAY   = 1;
  localparam int GR_RANDOM  = 2;

  typedef struct {
    logic       frameN, validN, dataIn, grantIn;
    logic       expReq, expValid, expFrame, expDout, expErr;
    logic [3:0] expAddr;
  } vec_t;

  typedef struct {
    logic last;
    logic dataBit;
  } refEntry_t;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_n = 1'b1;
  logic       valid_n = 1'b1;
  logic       din     = 1'b0;
  logic       grant   = 1'b0;
  logic [3:0] address_o;
  logic       request_o, frame_o, valid_o, dout, err_o;

  int checks   = 0;
  int failures = 0;
  int obsPops  = 0;
  int obsErrs  = 0;

  // Reference model: expected FIFO contents plus the last replayed bit/flag.
  refEntry_t refQ[$];
  logic      expDout  = 1'b0;
  logic      expFrame = 1'b1;

  vec_t tbl[15];

  router_input_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .din       (din),
    .grant     (grant),
    .address_o (address_o),
    .request_o (request_o),
    .frame_o   (frame_o),
    .valid_o   (valid_o),
    .dout      (dout),
    .err_o     (err_o)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(logic f, logic v, logic d, logic g, logic rq,
                                 logic vl, logic fr, logic dO, logic er, logic [3:0] ad);
    vec_t r;
    r.frameN = f;  r.validN = v;  r.dataIn = d;   r.grantIn = g;
    r.expReq = rq; r.expValid = vl; r.expFrame = fr; r.expDout = dO;
    r.expErr = er; r.expAddr = ad;
    return r;
  endfunction

  function automatic logic pickGrant(int mode, int afterCnt, int delay);
    if (mode == GR_ALWAYS) return 1'b1;
    if (mode == GR_DELAY)  return (afterCnt > delay);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at a falling edge; outputs are read at the next falling edge.
  task automatic applyStimulus(input logic f, input logic v, input logic d, input logic g);
    frame_n = f;
    valid_n = v;
    din     = d;
    grant   = g;
    @(negedge clock);
    if (!valid_o) obsPops++;
    if (err_o)    obsErrs++;
  endtask

  task automatic step(input logic f, input logic v, input logic d, input logic g, input bit isData);
    bit        doPop;
    bit        dropped;
    refEntry_t e;
    doPop   = g && (refQ.size() > 0);
    dropped = 1'b0;
    if (doPop) begin
      e        = refQ.pop_front();
      expDout  = e.dataBit;
      expFrame = e.last;
    end
    if (isData) begin
      if (refQ.size() < DEPTH) begin
        e.last    = f;
        e.dataBit = d;
        refQ.push_back(e);
      end else begin
        dropped = 1'b1;
        if (f) begin
          e      = refQ[refQ.size()-1];
          e.last = 1'b1;
          refQ[refQ.size()-1] = e;
        end
      end
    end
    applyStimulus(f, v, d, g);
    checkOutput("valid_o", valid_o, !doPop);
    checkOutput("dout", dout, expDout);
    checkOutput("frame_o", frame_o, expFrame);
    checkOutput("err_o", err_o, dropped);
  endtask

  task automatic runPacket(input logic [3:0] addr, input int pad, input int len,
                           input logic [15:0] payload, input int mode, input int delay, input bit gaps);
    int k;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, addr[i], pickGrant(mode, 0, delay), 1'b0);
    checkOutput("address_o", address_o, addr);
    checkOutput("request_o_up", request_o, 1);
    for (int i = 0; i < pad; i++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), pickGrant(mode, 0, delay), 1'b0);
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0)
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), pickGrant(mode, 0, delay), 1'b0);
      step(1'(i == len - 1), 1'b0, payload[i], pickGrant(mode, 0, delay), 1'b1);
    end
    k = 0;
    while (refQ.size() > 0 && k < 60) begin
      k++;
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)), pickGrant(mode, k, delay), 1'b0);
    end
    if (refQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_budget: got %0d entries left, expected 0", refQ.size());
      refQ.delete();
    end
    checkOutput("request_o_drop", request_o, 0);
  endtask

  initial begin
    logic [3:0] a;
    $display("[TB] start");

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst_address_o", address_o, 0);
    checkOutput("rst_request_o", request_o, 0);
    checkOutput("rst_frame_o", frame_o, 1);
    checkOutput("rst_valid_o", valid_o, 1);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_err_o", err_o, 0);
    reset_n = 1'b1;

    // Address 4'b1011 LSB-first, 5 pads, payload 1,0,1,1, grant high
    tbl[0]  = mkVec(0, 1, 1, 1,  0, 1, 1, 0, 0, 4'd0);
    tbl[1]  = mkVec(0, 1, 1, 1,  0, 1, 1, 0, 0, 4'd0);
    tbl[2]  = mkVec(0, 1, 0, 1,  0, 1, 1, 0, 0, 4'd0);
    tbl[3]  = mkVec(0, 1, 1, 1,  1, 1, 1, 0, 0, 4'd11);
    for (int i = 4; i <= 8; i++) tbl[i] = mkVec(0, 1, 0, 1,  1, 1, 1, 0, 0, 4'd11);
    tbl[9]  = mkVec(0, 0, 1, 1,  1, 1, 1, 0, 0, 4'd11);
    tbl[10] = mkVec(0, 0, 0, 1,  1, 0, 0, 1, 0, 4'd11);
    tbl[11] = mkVec(0, 0, 1, 1,  1, 0, 0, 0, 0, 4'd11);
    tbl[12] = mkVec(1, 0, 1, 1,  1, 0, 0, 1, 0, 4'd11);
    tbl[13] = mkVec(1, 1, 0, 1,  0, 0, 1, 1, 0, 4'd11);
    tbl[14] = mkVec(1, 1, 0, 1,  0, 1, 1, 1, 0, 4'd11);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].frameN, tbl[i].validN, tbl[i].dataIn, tbl[i].grantIn);
      checkOutput($sformatf("tbl%0d_request_o", i), request_o, tbl[i].expReq);
      checkOutput($sformatf("tbl%0d_valid_o", i), valid_o, tbl[i].expValid);
      checkOutput($sformatf("tbl%0d_frame_o", i), frame_o, tbl[i].expFrame);
      checkOutput($sformatf("tbl%0d_dout", i), dout, tbl[i].expDout);
      checkOutput($sformatf("tbl%0d_err_o", i), err_o, tbl[i].expErr);
      checkOutput($sformatf("tbl%0d_address_o", i), address_o, tbl[i].expAddr);
    end
    expDout  = tbl[14].expDout;
    expFrame = tbl[14].expFrame;

    // Same packet, grant held low until 6 cycles after the last payload bit
    obsPops = 0; obsErrs = 0;
    runPacket(4'd11, 5, 4, 16'b1101, GR_DELAY, 6, 1'b0);
    checkOutput("late_grant_pops", obsPops, 4);
    checkOutput("late_grant_errs", obsErrs, 0);

    // 12-bit payload into an 8-entry FIFO with grant low: bits 9..12 dropped
    obsPops = 0; obsErrs = 0;
    runPacket(4'd2, 1, 12, 16'hA5C, GR_DELAY, 1, 1'b0);
    checkOutput("overflow_pops", obsPops, 8);
    checkOutput("overflow_errs", obsErrs, 4);

    // Abort during the second pad cycle of address 3
    a = 4'd3;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, a[i], 1'b1, 1'b0);
    checkOutput("abort_addr", address_o, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_req_pad", request_o, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("abort_err", err_o, 1);
    checkOutput("abort_req", request_o, 0);
    checkOutput("abort_addr_hold", address_o, 3);
    checkOutput("abort_valid", valid_o, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("abort_err_single", err_o, 0);
    runPacket(4'd7, 1, 4, 16'b0110, GR_ALWAYS, 0, 1'b0);

    // Back-to-back packets with a one-cycle gap
    runPacket(4'd5, 1, 3, 16'b110, GR_ALWAYS, 0, 1'b0);
    runPacket(4'd9, 0, 5, 16'b10011, GR_ALWAYS, 0, 1'b0);

    // Reset asserted mid-payload with three bits buffered
    a = 4'd6;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, a[i], 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'(i != 1), 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_address_o", address_o, 0);
    checkOutput("midrst_request_o", request_o, 0);
    checkOutput("midrst_frame_o", frame_o, 1);
    checkOutput("midrst_valid_o", valid_o, 1);
    checkOutput("midrst_dout", dout, 0);
    checkOutput("midrst_err_o", err_o, 0);
    refQ.delete();
    expDout  = 1'b0;
    expFrame = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    runPacket(4'd0, 2, 3, 16'b011, GR_ALWAYS, 0, 1'b0);

    // Randomized packets
    for (int n = 0; n < 20; n++) begin
      runPacket(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(2, 12),
                16'($urandom), $urandom_range(0, 2), $urandom_range(0, 8),
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_input_ctrl.md
Name: router_input_ctrl

Overview:
- Per-input-port front end of the 16x16 router; sits directly upstream of the decode stage.
- Deserialises the 4-bit destination address from the serial din stream.
- Holds request and address to decode for the whole packet.
- Buffers payload bits in a small FIFO until the output arbiter grants, then replays frame_n/valid_n/din toward decode.

Parameters:
- DEPTH, 8, payload FIFO entries (power of 2, >=2); each entry is {last, bit}.
- ADDR_W, 4, address width; also the number of serial address cycles.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_n  in  1  active-low frame from the port driver; low for the whole packet, high on the last payload bit.
- valid_n  in  1  active-low payload-bit valid; high during address and pad cycles.
- din  in  1  serial data, LSB-first address followed by payload.
- grant  in  1  arbiter grant for address_o; level, sampled each clock.
- address_o  out  ADDR_W  captured destination, to decode address.
- request_o  out  1  to decode request.
- frame_o  out  1  active-low replayed frame, to decode frame_n.
- valid_o  out  1  active-low replayed valid, to decode valid_n.
- dout  out  1  replayed data bit, to decode din.
- err_o  out  1  one-cycle error pulse.

Behaviour:
- Reset (async, any state): IDLE, FIFO empty, address_o=0, request_o=0, frame_o=1, valid_o=1, dout=0, err_o=0.
- All outputs are registered.
- Input FSM states: IDLE, ADDR, PAD, DATA, DRAIN.
- IDLE: sampled frame_n=0 latches din as address bit0, cnt=1, go to ADDR.
- ADDR: latches din into bit cnt; after bit ADDR_W-1, go to PAD.
  - address_o updates and request_o=1 on the clock after the 4th address bit.
- Abort: frame_n=1 in ADDR or PAD means:
  - return to IDLE;
  - request_o=0 next cycle;
  - err_o pulses;
  - address_o holds its last value.
- PAD: cycles with valid_n=1 are ignored, with no cycle limit. The first valid_n=0 goes to DATA and is pushed.
- DATA: each cycle with valid_n=0 pushes {last=frame_n, din}.
  - A pushed entry with last=1 moves to DRAIN; no further pushes.
  - valid_n=1 in DATA is a gap; no push.
- FIFO full with valid_n=0:
  - the bit is dropped and err_o pulses;
  - if the dropped bit had last=1, the entry at the write tail gets last forced to 1 so the packet still terminates.
- DRAIN: waits for FIFO empty and the last entry popped.
  - Then request_o=0 on the next clock and the FSM returns to IDLE.
  - frame_n=0 sampled in DRAIN pulses err_o and is ignored; the driver guarantees a gap of 1 or more cycles.
- Output side: pop when grant=1, FIFO non-empty and request_o=1; one pop per cycle.
- Pop cycle next clock: dout=bit, valid_o=0, frame_o=last.
- No-pop cycle after the first pop of a packet: valid_o=1, frame_o=0, dout holds.
- frame_o returns to 1 after the last pop.
- Latency: a push at cycle t with grant already high shows on dout at t+2 (FIFO write, then registered pop). A push and pop on the same entry in the same cycle are not allowed; read uses registered occupancy.
- Simultaneous push and pop when full: the pop frees space first, the push is accepted, and there is no error.
- grant deasserting mid-packet stalls the replay only; nothing is lost.
- Pointers wrap modulo DEPTH; an extra MSB bit distinguishes full from empty.

Decomposition:
- Shared package router_pkg holds:
  - ADDR_W and PORTS=16;
  - an input FSM state enum;
  - a FIFO entry struct {last, bit}.
- One sub-module: router_bit_fifo (DEPTH x 2-bit synchronous FIFO, async active-low reset, push/pop/full/empty).

Test Plan:
- Address 4'b1011 sent LSB-first, 5 pad cycles, payload 1,0,1,1 with grant=1 throughout:
  - address_o=11 and request_o=1 after the 4th address clock;
  - dout replays 1,0,1,1 with valid_o=0 and frame_o=1 on the 4th bit;
  - request_o=0 after.
- Same packet with grant held low until 6 cycles after the last payload bit: nothing on valid_o, then 4 consecutive pops, no err_o.
- 12-bit payload, DEPTH=8, grant low throughout: err_o pulses on bits 9..12; after grant, 8 bits replay with frame_o=1 on the 8th.
- frame_n rises during the 2nd pad cycle (address 3): err_o one pulse, request_o drops, FSM returns to IDLE, the next packet is accepted normally.
- reset_n asserted mid-DATA with 3 bits buffered: outputs immediately at reset values, FIFO empty, and a subsequent packet with address 0 works.
- Back-to-back packets with a 1-cycle gap, addresses 5 then 9, grant=1: both are replayed intact, with request_o low for at least 1 cycle between them.
